sync_fifo_param: RTL and testbench

Single-clock, parametrised successor to the dual-clock FIFO2. Generalised data width and depth, programmable almost-full/almost-empty thresholds, live fill count, sticky overflow/underflow error flags, and selectable read mode (registered-output or first-word-fall-through). Used as a same-domain elastic buffer between pipeline stages.

---
 rtl/sync_fifo_param.sv | 130 +++++++++++++
 tb/tb_sync_fifo_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with almost-full/empty thresholds, fill count,
// sticky overflow/underflow flags and selectable registered or FWFT read port.
module sync_fifo_param #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned AFULL_TH  = 14,
   parameter int unsigned AEMPTY_TH = 2,
   parameter int unsigned FWFT      = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              winc,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rinc,
   output logic [DATA_W-1:0] rdata,
   output logic              wfull,
   output logic              afull,
   output logic              rempty,
   output logic              aempty,
   output logic [ADDR_W:0]   fill_cnt,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [PTR_W-1:0]  wptr_nxt;
   logic [PTR_W-1:0]  rptr_nxt;
   logic [PTR_W-1:0]  cnt_nxt;
   logic              wr_acc;
   logic              rd_acc;
   logic              wfull_nxt;
   logic              rempty_nxt;
   logic              afull_nxt;
   logic              aempty_nxt;
   logic              overflow_nxt;
   logic              underflow_nxt;
   logic [DATA_W-1:0] rdata_nxt;

   // Next-state decode; flags are computed from next pointers and then registered
   always_comb begin
      wr_acc        = winc && !wfull;
      rd_acc        = rinc && !rempty;
      wptr_nxt      = wptr;
      rptr_nxt      = rptr;
      rdata_nxt     = rdata;
      overflow_nxt  = overflow;
      underflow_nxt = underflow;

      if (wr_acc) begin
         wptr_nxt = wptr + PTR_W'(1);
      end
      if (rd_acc) begin
         rptr_nxt = rptr + PTR_W'(1);
      end

      cnt_nxt    = wptr_nxt - rptr_nxt;
      rempty_nxt = (wptr_nxt == rptr_nxt);
      wfull_nxt  = (wptr_nxt[ADDR_W-1:0] == rptr_nxt[ADDR_W-1:0]) &&
                   (wptr_nxt[ADDR_W] != rptr_nxt[ADDR_W]);
      afull_nxt  = (cnt_nxt >= PTR_W'(AFULL_TH));
      aempty_nxt = (cnt_nxt <= PTR_W'(AEMPTY_TH));

      // Set beats clear when both happen in the same cycle
      if (clr_err) begin
         overflow_nxt  = 1'b0;
         underflow_nxt = 1'b0;
      end
      if (winc && wfull) begin
         overflow_nxt = 1'b1;
      end
      if (rinc && rempty) begin
         underflow_nxt = 1'b1;
      end

      // FWFT keeps the head word staged; a write into an empty FIFO bypasses memory
      if (FWFT != 0) begin
         if (rd_acc || (wr_acc && rempty)) begin
            if (wr_acc && (rptr_nxt == wptr)) begin
               rdata_nxt = wdata;
            end else begin
               rdata_nxt = mem[rptr_nxt[ADDR_W-1:0]];
            end
         end
      end else if (rd_acc) begin
         rdata_nxt = mem[rptr[ADDR_W-1:0]];
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         fill_cnt  <= '0;
         rempty    <= 1'b1;
         aempty    <= 1'b1;
         wfull     <= 1'b0;
         afull     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         rdata     <= '0;
      end else begin
         wptr      <= wptr_nxt;
         rptr      <= rptr_nxt;
         fill_cnt  <= cnt_nxt;
         rempty    <= rempty_nxt;
         aempty    <= aempty_nxt;
         wfull     <= wfull_nxt;
         afull     <= afull_nxt;
         overflow  <= overflow_nxt;
         underflow <= underflow_nxt;
         rdata     <= rdata_nxt;
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wptr[ADDR_W-1:0]] <= wdata;
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: registered-read instance checked against a
// queue model, plus a first-word-fall-through instance with directed checks.
module tb_sync_fifo_param;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;

   logic       winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       wfull, afull, rempty, aempty, overflow, underflow;
   logic [4:0] fill_cnt;

   logic       w1 = 1'b0, r1 = 1'b0, c1 = 1'b0;
   logic [7:0] d1 = 8'h00;
   logic [7:0] rdata1;
   logic       wfull1, afull1, rempty1, aempty1, overflow1, underflow1;
   logic [4:0] fill_cnt1;

   int         n_vec = 0;
   int         n_err = 0;

   logic [7:0] m_q[$];
   logic [7:0] exp_q[$];
   logic       m_ovf = 1'b0, m_unf = 1'b0;
   logic       rd_expect = 1'b0;
   logic       pend = 1'b0;
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata),
      .wfull(wfull), .afull(afull), .rempty(rempty), .aempty(aempty), .fill_cnt(fill_cnt),
      .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
   );

   sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .winc(w1), .wdata(d1), .rinc(r1), .rdata(rdata1),
      .wfull(wfull1), .afull(afull1), .rempty(rempty1), .aempty(aempty1), .fill_cnt(fill_cnt1),
      .overflow(overflow1), .underflow(underflow1), .clr_err(c1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      int n;
      n = m_q.size();
      chk({tag, ".fill_cnt"},  32'(fill_cnt),  32'(n));
      chk({tag, ".wfull"},     32'(wfull),     32'(n == 16));
      chk({tag, ".rempty"},    32'(rempty),    32'(n == 0));
      chk({tag, ".afull"},     32'(afull),     32'(n >= 14));
      chk({tag, ".aempty"},    32'(aempty),    32'(n <= 2));
      chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
      chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
   endtask

   // One clock of stimulus on u0; called at a falling edge, returns at the next one
   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c,
                       input string tag);
      logic wa, ra;
      wa = w && (m_q.size() < 16);
      ra = r && (m_q.size() != 0);
      winc = w; wdata = d; rinc = r; clr_err = c; rd_expect = ra;
      if (ra) exp_q.push_back(m_q.pop_front());
      if (wa) m_q.push_back(d);
      m_ovf = (w && !wa) ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (r && !ra) ? 1'b1 : (c ? 1'b0 : m_unf);
      @(posedge clk);
      @(negedge clk);
      winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; rd_expect = 1'b0;
      chk_model(tag);
   endtask

   task automatic pulse_rst(input string tag);
      #1 rst_n = 1'b0;
      #1;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      chk({tag, ".fill_cnt"},  32'(fill_cnt),  32'd0);
      chk({tag, ".rempty"},    32'(rempty),    32'd1);
      chk({tag, ".aempty"},    32'(aempty),    32'd1);
      chk({tag, ".wfull"},     32'(wfull),     32'd0);
      chk({tag, ".afull"},     32'(afull),     32'd0);
      chk({tag, ".overflow"},  32'(overflow),  32'd0);
      chk({tag, ".underflow"}, 32'(underflow), 32'd0);
      chk({tag, ".rdata"},     32'(rdata),     32'd0);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: a read accepted at an edge must show its word by the next falling edge
   always @(posedge clk) pend <= rd_expect;

   always @(negedge clk) begin
      if (pend) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb.underrun: got 0x%0h, expected no read data", rdata);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("sb.rdata", 32'(rdata), 32'(mon_exp));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.fill_cnt",  32'(fill_cnt),  32'd0);
      chk("rst.rempty",    32'(rempty),    32'd1);
      chk("rst.aempty",    32'(aempty),    32'd1);
      chk("rst.wfull",     32'(wfull),     32'd0);
      chk("rst.afull",     32'(afull),     32'd0);
      chk("rst.overflow",  32'(overflow),  32'd0);
      chk("rst.underflow", 32'(underflow), 32'd0);
      chk("rst.rdata",     32'(rdata),     32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fill, thresholds, overflow
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      chk("fill.cnt16", 32'(fill_cnt), 32'd16);
      chk("fill.wfull", 32'(wfull),    32'd1);
      step(1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
      chk("ovf.cnt",  32'(fill_cnt), 32'd16);
      chk("ovf.flag", 32'(overflow), 32'd1);

      // Drain in order, then underflow with rdata held
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      chk("drain.rempty", 32'(rempty), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, "unf");
      chk("unf.flag",  32'(underflow), 32'd1);
      chk("unf.rdata", 32'(rdata),     32'h0F);

      // Wrapped pointers: three more words through
      step(1'b1, 8'h11, 1'b0, 1'b0, "wrap_w");
      step(1'b1, 8'h22, 1'b0, 1'b0, "wrap_w");
      step(1'b1, 8'h33, 1'b0, 1'b0, "wrap_w");
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_r");
      chk("wrap.rdata", 32'(rdata),    32'h33);
      chk("wrap.cnt",   32'(fill_cnt), 32'd0);

      // Simultaneous at full
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "fill2");
      step(1'b1, 8'hEE, 1'b1, 1'b0, "sim_full");
      chk("sim_full.cnt", 32'(fill_cnt), 32'd15);
      chk("sim_full.ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");

      // Simultaneous at empty
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
      step(1'b1, 8'hC3, 1'b1, 1'b0, "sim_empty");
      chk("sim_empty.cnt", 32'(fill_cnt),  32'd1);
      chk("sim_empty.unf", 32'(underflow), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, "sim_empty_rd");
      chk("sim_empty.rdata", 32'(rdata), 32'hC3);

      // Steady state at half full
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "half");
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h90 + i), 1'b1, 1'b0, "sim_half");
      chk("sim_half.cnt", 32'(fill_cnt), 32'd8);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain3");
      chk("drain3.rdata", 32'(rdata), 32'h99);

      // Error flag clearing
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, "fill3");
      step(1'b1, 8'h55, 1'b0, 1'b0, "ovf2");
      chk("ovf2.flag", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr_only");
      chk("clr_only.ovf", 32'(overflow), 32'd0);
      step(1'b1, 8'h66, 1'b0, 1'b1, "clr_and_ovf");
      chk("clr_and_ovf.ovf", 32'(overflow), 32'd1);

      // Reset mid-operation
      pulse_rst("rst_full");
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "pre_rst");
      chk("pre_rst.cnt", 32'(fill_cnt), 32'd5);
      pulse_rst("rst_mid");
      step(1'b1, 8'h77, 1'b0, 1'b0, "post_rst_w");
      chk("post_rst.cnt", 32'(fill_cnt), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_r");
      chk("post_rst.rdata", 32'(rdata), 32'h77);
      step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

      // First-word-fall-through instance
      w1 = 1'b1; d1 = 8'h5A;
      @(posedge clk); @(negedge clk);
      w1 = 1'b0;
      chk("fwft.rempty0", 32'(rempty1), 32'd0);
      chk("fwft.rdata5A", 32'(rdata1),  32'h5A);
      w1 = 1'b1; d1 = 8'h6B;
      @(posedge clk); @(negedge clk);
      w1 = 1'b0;
      chk("fwft.hold5A", 32'(rdata1),    32'h5A);
      chk("fwft.cnt2",   32'(fill_cnt1), 32'd2);
      r1 = 1'b1;
      @(posedge clk); @(negedge clk);
      r1 = 1'b0;
      chk("fwft.rdata6B", 32'(rdata1),  32'h6B);
      chk("fwft.rempty1", 32'(rempty1), 32'd0);
      r1 = 1'b1;
      @(posedge clk); @(negedge clk);
      r1 = 1'b0;
      chk("fwft.empty",  32'(rempty1),    32'd1);
      chk("fwft.no_unf", 32'(underflow1), 32'd0);

      @(negedge clk);
      chk("sb.drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
